// File: rtl/shift_pkg.sv
// Shared constants and types for the multi-cycle shift sequencer.
// Op encoding is shared with the single-cycle shifter.
package shift_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 4;

    localparam logic [2:0] SFT_PASS = 3'd0;
    localparam logic [2:0] SFT_L    = 3'd1;
    localparam logic [2:0] SFT_R    = 3'd2;
    localparam logic [2:0] ROT_L    = 3'd3;
    localparam logic [2:0] ROT_R    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= ROT_R;
    endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Command/result bundle between the control unit and the shift sequencer.
// master = control unit side, slave = sequencer side.
interface shift_seq_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, count, data_in,
        input  busy, done, err, result
    );

    modport slave (
        input  start, op, count, data_in,
        output busy, done, err, result
    );
endinterface

// File: rtl/shift_step.sv
// Combinational one-bit shift/rotate step; zero latency, no flow control.
// Non-shift ops (pass, illegal) produce 0.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            SFT_L:   y_o = {a_i[WIDTH-2:0], 1'b0};
            SFT_R:   y_o = {1'b0, a_i[WIDTH-1:1]};
            ROT_L:   y_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
            ROT_R:   y_o = {a_i[0], a_i[WIDTH-1:1]};
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-bit shift/rotate sequencer: one bit per clock, done pulse after count+1 cycles.
// Stalls the caller with busy; start is only honoured in IDLE.
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    shift_seq_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] step_y;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op_i (op_q),
        .a_i  (acc_q),
        .y_o  (step_y)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    acc_d = bus.data_in;
                    cnt_d = bus.count;
                    err_d = 1'b0;
                    if (!op_legal(bus.op)) begin
                        acc_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (bus.op == SFT_PASS || bus.count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = step_y;
                cnt_d = cnt_q - 1'b1;
                // cnt_q is the number of steps still owed including this one
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.err    = err_q;
    assign bus.result = acc_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: vector table plus start-ignore and async-reset sequences.
module tb_shift_seq;
    import shift_pkg::*;

    logic clk;
    logic rst_n;

    shift_seq_if #(.WIDTH(16), .CNT_W(4)) bus ();

    shift_seq #(.WIDTH(16), .CNT_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  cnt;
        logic [15:0] din;
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_n;
    } vec_t;

    vec_t vecs[11];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of cycle N+2.
    task automatic run_vec(input vec_t v, input int idx);
        int done_cyc;
        int done_cnt;
        int busy_bad;
        bus.start   = 1'b1;
        bus.op      = v.op;
        bus.count   = v.cnt;
        bus.data_in = v.din;
        done_cyc = 0;
        done_cnt = 0;
        busy_bad = 0;
        for (int c = 1; c <= v.exp_n + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start   = 1'b0;
                bus.op      = 3'd2;
                bus.count   = 4'd9;
                bus.data_in = 16'h5A5A;
            end
            if (bus.busy !== (c <= v.exp_n + 1)) busy_bad++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c == v.exp_n + 1) begin
                check($sformatf("v%0d result", idx), 32'(bus.result), 32'(v.exp_res));
                check($sformatf("v%0d err", idx), 32'(bus.err), 32'(v.exp_err));
            end
            if (c == v.exp_n + 2) begin
                check($sformatf("v%0d result held", idx), 32'(bus.result), 32'(v.exp_res));
                check($sformatf("v%0d err held", idx), 32'(bus.err), 32'(v.exp_err));
            end
        end
        check($sformatf("v%0d busy profile errors", idx), 32'(busy_bad), 32'd0);
        check($sformatf("v%0d done cycle", idx), 32'(done_cyc), 32'(v.exp_n + 1));
        check($sformatf("v%0d done pulses", idx), 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int done_cnt;
        int done_cyc;
        vec_t fresh;
        n_checks = 0;
        n_fail   = 0;

        //          op     cnt    din       exp_res   err   N
        vecs[0]  = '{ROT_L,    4'd4,  16'h8001, 16'h0018, 1'b0, 4};
        vecs[1]  = '{SFT_R,    4'd15, 16'h8000, 16'h0001, 1'b0, 15};
        vecs[2]  = '{SFT_L,    4'd15, 16'hFFFF, 16'h8000, 1'b0, 15};
        vecs[3]  = '{ROT_R,    4'd1,  16'h0001, 16'h8000, 1'b0, 1};
        vecs[4]  = '{SFT_PASS, 4'd7,  16'h1234, 16'h1234, 1'b0, 0};
        vecs[5]  = '{SFT_L,    4'd0,  16'hABCD, 16'hABCD, 1'b0, 0};
        vecs[6]  = '{3'd5,     4'd3,  16'hFFFF, 16'h0000, 1'b1, 0};
        vecs[7]  = '{SFT_L,    4'd3,  16'h0001, 16'h0008, 1'b0, 3};
        vecs[8]  = '{3'd7,     4'd0,  16'h1111, 16'h0000, 1'b1, 0};
        vecs[9]  = '{ROT_R,    4'd2,  16'h0003, 16'hC000, 1'b0, 2};
        vecs[10] = '{SFT_R,    4'd4,  16'h00F0, 16'h000F, 1'b0, 4};

        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.count   = 4'd0;
        bus.data_in = 16'h0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy",   32'(bus.busy),   32'd0);
        check("reset done",   32'(bus.done),   32'd0);
        check("reset err",    32'(bus.err),    32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // start re-asserted in SHIFT cycles 1..3 and in the DONE cycle must be ignored
        bus.start = 1'b1; bus.op = ROT_L; bus.count = 4'd4; bus.data_in = 16'h8001;
        done_cnt = 0;
        done_cyc = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c == 5) check("ignore result", 32'(bus.result), 32'h0018);
            bus.start   = (c <= 3 || c == 5);
            bus.op      = SFT_R;
            bus.count   = 4'd2;
            bus.data_in = 16'h5555;
        end
        check("ignore done cycle",  32'(done_cyc), 32'd5);
        check("ignore done pulses", 32'(done_cnt), 32'd1);
        check("ignore idle busy",   32'(bus.busy), 32'd0);
        check("ignore final result", 32'(bus.result), 32'h0018);

        // async reset in cycle 3 of a 10-step shift
        bus.start = 1'b1; bus.op = SFT_L; bus.count = 4'd10; bus.data_in = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre-reset busy",   32'(bus.busy),   32'd1);
        check("pre-reset result", 32'(bus.result), 32'h0004);
        #2 rst_n = 1'b0;
        #1;
        check("async busy",   32'(bus.busy),   32'd0);
        check("async done",   32'(bus.done),   32'd0);
        check("async err",    32'(bus.err),    32'd0);
        check("async result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
        end
        check("post-reset no activity", 32'(done_cnt), 32'd0);
        fresh = '{SFT_L, 4'd2, 16'h0001, 16'h0004, 1'b0, 2};
        run_vec(fresh, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-bit shift/rotate sequencer for the KX9016 16-bit datapath. It accepts one shift command (operation, data, distance 0–15) and iterates a single-bit combinational shift step once per clock until the requested distance is reached. It then presents the result with a one-cycle done pulse. It sits between the control unit and the register file write path and stalls the control unit via `busy`.

## Interface
Parameters:
- `WIDTH`, 16: data width. Only 16 is supported.
- `CNT_W`, 4: shift-distance width. The distance range is 0..2^CNT_W−1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  command strobe, sampled only in IDLE
- `op`  in  3  0 pass, 1 sftl, 2 sftr, 3 rotl, 4 rotr, 5–7 illegal
- `count`  in  CNT_W  shift distance
- `data_in`  in  WIDTH  operand
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle pulse; `result` is valid
- `err`  out  1  set with `done` when `op` was illegal; held until the next accepted start
- `result`  out  WIDTH  shifted value; held until the next accepted start

## Operation
- States: IDLE, SHIFT, DONE. Registers: `acc` (WIDTH), `cnt` (CNT_W), `op_r` (3), `err_r`.
- IDLE, `start`=1:
  - Latch `op_r`←`op`, `acc`←`data_in`, `cnt`←`count`, `err_r`←0.
  - Illegal op: `acc`←0, `err_r`←1, go to DONE.
  - `op`=pass or `count`=0: go to DONE. `acc` keeps `data_in`.
  - Otherwise: go to SHIFT.
- SHIFT, each cycle:
  - `acc`←step(`op_r`, `acc`), `cnt`←`cnt`−1.
  - If `cnt`==1, go to DONE.
- step() is a one-bit operation:
  - sftl: {acc[14:0],0}
  - sftr: {0,acc[15:1]}
  - rotl: {acc[14:0],acc[15]}
  - rotr: {acc[0],acc[15:1]}
- DONE: `done`=1 for this cycle only, then unconditionally go to IDLE.
- `result` is driven directly by `acc`; `err` is driven by `err_r`.
- `start` outside IDLE is ignored and has no side effects. This includes `start` in the DONE cycle.
- `op`, `count` and `data_in` are don't-care except in the cycle where `start` is accepted.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `acc`, `cnt`, `op_r` and `err_r` clear to 0.
  - Outputs: `busy`=0, `done`=0, `err`=0, `result`=0.
  - A command in flight is discarded. No `done` is produced for it.

## Timing
- Take the cycle in which `start` is accepted as cycle 0.
- `busy` is high in cycles 1..N+1 and `done` is high in cycle N+1, where:
  - N = `count` for legal shift ops;
  - N = 0 for pass, for `count`=0, and for illegal ops.
- Latency is therefore `count`+1 cycles; the worst case is 16 cycles.
- The earliest next accepted `start` is cycle N+2, since IDLE is re-entered then. Throughput is one command per N+2 cycles.
- `done` and `err` are registered; there is no combinational path from inputs to outputs.
- `result` changes only on accepted-start and SHIFT edges. It is stable from the `done` cycle until the next accepted start.

## Structure
- Package `shift_pkg`:
  - op encoding constants: `SFT_PASS`=0, `SFT_L`=1, `SFT_R`=2, `ROT_L`=3, `ROT_R`=4. These match the single-cycle shifter encoding.
  - state enum (IDLE/SHIFT/DONE).
  - `WIDTH`/`CNT_W` defaults.
- Sub-module `shift_step`: purely combinational one-bit step, (op, a) → y. It outputs 0 for non-shift ops. It is instantiated once in `shift_seq` on the `acc` feedback path.
- `shift_seq` contains the FSM, the counter and the `acc`/`op_r`/`err_r` registers.

## Test plan
- rotl, `data_in`=0x8001, `count`=4 → `done` in cycle 5, `result`=0x0018, `err`=0; `busy` high in cycles 1–5.
- sftr, `data_in`=0x8000, `count`=15 → `done` in cycle 16, `result`=0x0001. Then sftl, 0xFFFF, 15 → 0x8000.
- rotr 0x0001 by 1 → 0x8000 in cycle 2. Pass 0x1234 with `count`=7 → 0x1234 in cycle 1. sftl 0xABCD with `count`=0 → 0xABCD in cycle 1.
- `op`=5, `data_in`=0xFFFF → `done` and `err`=1 in cycle 1, `result`=0x0000. The next legal command clears `err`.
- Re-assert `start` with a different op and data in cycles 1–3 of a 4-step rotl, and in the `done` cycle → both are ignored and `result` matches the first command only.
- Assert `rst_n`=0 asynchronously mid-SHIFT (cycle 3 of a 10-step shift) → `busy`, `done`, `err` and `result` are 0 immediately, with no later `done`. After release, a fresh command completes normally.
